ysyx_25040109_mdu: RTL and testbench
====================================

Name: ysyx_25040109_mdu

Overview:
- Multi-cycle RV32M/RV64M-style multiply/divide unit with valid/ready handshakes on its input and output.
- Sits beside the EXU ALU and takes over all M-extension ops. Adds MULHSU/MULHU, a pipelined multiplier, an iterative radix-2 divider, backpressure and flush.
- Width is parametrised. A destination tag travels with each op so writeback can match the result.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_STAGES, 2, multiply latency in cycles from accept to out_valid (1..4).
- TAG_W, 5, width of the passthrough tag (rd address).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  op request
- in_ready  out  1  unit can accept
- in_funct3  in  3  RV M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_a  in  XLEN  rs1 operand
- in_b  in  XLEN  rs2 operand
- in_tag  in  TAG_W  rd address, returned unchanged
- flush  in  1  abort in-flight op
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  result
- out_tag  out  TAG_W  tag of the op
- busy  out  1  state != IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, busy=0, counters=0.
- FSM states: IDLE, MUL, DIV, DONE.
- in_ready=1 only in IDLE. An op is accepted on a clock edge where in_valid&in_ready. Operands, funct3 and tag are latched at accept.
- Transitions from IDLE on accept:
  - funct3[2]=0 -> MUL.
  - funct3[2]=1 and special case -> DONE directly.
  - Otherwise -> DIV.
- Latency, with accept at edge T, out_valid=1 from cycle T+L:
  - MUL ops: L=MUL_STAGES.
  - Non-special DIV/DIVU/REM/REMU: L=XLEN+1 (1 setup cycle: absolute values; XLEN restoring iterations, the last also applying the sign fix).
  - Special cases: L=1.
- Special cases:
  - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
  - Signed overflow (a==MIN_INT, b==-1): DIV -> MIN_INT; REM -> 0.
- Multiply: 2*XLEN product.
  - MUL -> low XLEN.
  - MULH: signed x signed, high XLEN.
  - MULHSU: signed a x unsigned b, high XLEN.
  - MULHU: unsigned x unsigned, high XLEN.
- Signed div: quotient sign = sign(a)^sign(b); remainder sign = sign(a). Truncation toward zero.
- DONE: out_valid=1; out_result/out_tag held stable until out_ready=1. At the edge with out_valid&out_ready -> IDLE, out_valid=0 next cycle. No back-to-back accept in the same edge as the handoff.
- flush=1 at an edge:
  - Forces IDLE from any state; out_valid=0 next cycle.
  - Wins over a simultaneous accept (the op is dropped) and over a simultaneous out handshake (the result is considered not taken).
- in_* is ignored when in_ready=0. rst mid-operation behaves as flush plus clearing the counters.

Optional Feature:
- Macro: YSYX_25040109_MDU_PERF_EN.
- Defined:
  - Adds outputs perf_mul_cnt [31:0] and perf_div_cnt [31:0].
  - Each increments by 1 at every completed output handshake of the respective class (specials count as div).
  - Counters wrap at 2^32 and are cleared by rst only.
- Undefined: the ports are absent and there are no counters; the rest is identical.

Test Plan:
- MUL a=7, b=0xFFFFFFFD, XLEN=32, MUL_STAGES=2 -> out_result=0xFFFFFFEB, out_valid exactly 2 cycles after accept, tag echoed.
- MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF; MULH a=0x80000000, b=0x80000000 -> 0x40000000.
- DIV a=0xFFFFFFF9(-7), b=2 -> 0xFFFFFFFD after 33 cycles; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV b=0 -> 0xFFFFFFFF in 1 cycle; REMU a=5, b=0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/tag stable, in_ready=0; raise out_ready -> IDLE next cycle, new op accepted.
- flush at cycle 10 of a DIV -> IDLE next cycle, out_valid never asserts for that op; flush with in_valid in IDLE -> op not accepted; with PERF_EN, counters unchanged by flushed ops.

Source files
------------

// File: rtl/ysyx_25040109_mdu_if.sv
// rtl/ysyx_25040109_mdu_if.sv - request/response handshake bundle for the multiply/divide unit
interface ysyx_25040109_mdu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_funct3, in_a, in_b, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_result, out_tag, busy
  );

  modport slave (
    input  in_valid, in_funct3, in_a, in_b, in_tag, flush, out_ready,
    output in_ready, out_valid, out_result, out_tag, busy
  );
endinterface

// File: rtl/ysyx_25040109_mdu.sv
// rtl/ysyx_25040109_mdu.sv - RV M-extension multiply/divide unit with valid/ready handshakes
// Define YSYX_25040109_MDU_PERF_EN to add per-class completed-result counters.
module ysyx_25040109_mdu #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int TAG_W      = 5
) (
  input  logic clk,
  input  logic rst,
`ifdef YSYX_25040109_MDU_PERF_EN
  output logic [31:0] perf_mul_cnt,
  output logic [31:0] perf_div_cnt,
`endif
  ysyx_25040109_mdu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_STAGES - 2);
  localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic [XLEN-1:0]  r_out_result;
  logic [TAG_W-1:0] r_out_tag;
  logic [TAG_W-1:0] r_tag;
  logic [1:0]       r_op;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quot;
  logic [XLEN-1:0]  r_divisor;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [CW-1:0]    r_cnt;

  // Operands widened to 2*XLEN with per-op sign extension; the low half is sign-agnostic.
  function automatic logic [XLEN-1:0] mul_sel(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic              a_s;
    logic              b_s;
    logic [2*XLEN-1:0] a_x;
    logic [2*XLEN-1:0] b_x;
    logic [2*XLEN-1:0] p;
    a_s = a[XLEN-1] & (op != 2'b11);
    b_s = b[XLEN-1] & (op == 2'b01);
    a_x = {{XLEN{a_s}}, a};
    b_x = {{XLEN{b_s}}, b};
    p   = a_x * b_x;
    return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  logic            w_accept;
  logic            w_sdiv;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  assign w_accept      = bus.in_valid & r_in_ready;
  assign w_sdiv        = ~bus.in_funct3[0];
  assign w_b_zero      = (bus.in_b == '0);
  assign w_ovf         = w_sdiv & (bus.in_a == MIN_INT) & (bus.in_b == '1);
  assign w_special     = w_b_zero | w_ovf;
  assign w_special_res = w_b_zero ? (bus.in_funct3[1] ? bus.in_a : '1)
                                  : (bus.in_funct3[1] ? '0 : MIN_INT);
  assign w_abs_a       = (w_sdiv & bus.in_a[XLEN-1]) ? -bus.in_a : bus.in_a;
  assign w_abs_b       = (w_sdiv & bus.in_b[XLEN-1]) ? -bus.in_b : bus.in_b;

  // One restoring step: the dividend sits in r_quot and shifts out MSB-first into r_rem.
  logic [XLEN:0]   w_rem_sh;
  logic            w_fit;
  logic [XLEN-1:0] w_rem_nx;
  logic [XLEN-1:0] w_quot_nx;
  logic [XLEN-1:0] w_div_res;

  assign w_rem_sh  = {r_rem, r_quot[XLEN-1]};
  assign w_fit     = (w_rem_sh >= {1'b0, r_divisor});
  assign w_rem_nx  = w_fit ? (w_rem_sh[XLEN-1:0] - r_divisor) : w_rem_sh[XLEN-1:0];
  assign w_quot_nx = {r_quot[XLEN-2:0], w_fit};
  assign w_div_res = r_op[1] ? (r_neg_r ? -w_rem_nx : w_rem_nx)
                             : (r_neg_q ? -w_quot_nx : w_quot_nx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_cnt        <= '0;
    end else if (bus.flush) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= bus.in_funct3[1:0];
            r_tag      <= bus.in_tag;
            r_a        <= bus.in_a;
            r_b        <= bus.in_b;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (!bus.in_funct3[2]) begin
              if (MUL_STAGES == 1) begin
                r_state      <= DONE;
                r_out_valid  <= 1'b1;
                r_out_result <= mul_sel(bus.in_funct3[1:0], bus.in_a, bus.in_b);
                r_out_tag    <= bus.in_tag;
              end else begin
                r_state <= MUL;
              end
            end else if (w_special) begin
              r_state      <= DONE;
              r_out_valid  <= 1'b1;
              r_out_result <= w_special_res;
              r_out_tag    <= bus.in_tag;
            end else begin
              r_state   <= DIV;
              r_rem     <= '0;
              r_quot    <= w_abs_a;
              r_divisor <= w_abs_b;
              r_neg_q   <= w_sdiv & (bus.in_a[XLEN-1] ^ bus.in_b[XLEN-1]);
              r_neg_r   <= w_sdiv & bus.in_a[XLEN-1];
            end
          end
        end
        MUL: begin
          if (r_cnt == MUL_LAST) begin
            r_state      <= DONE;
            r_out_valid  <= 1'b1;
            r_out_result <= mul_sel(r_op, r_a, r_b);
            r_out_tag    <= r_tag;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DIV: begin
          r_rem  <= w_rem_nx;
          r_quot <= w_quot_nx;
          if (r_cnt == DIV_LAST) begin
            r_state      <= DONE;
            r_out_valid  <= 1'b1;
            r_out_result <= w_div_res;
            r_out_tag    <= r_tag;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_tag    = r_out_tag;
  assign bus.busy       = r_busy;

`ifdef YSYX_25040109_MDU_PERF_EN
  logic r_is_div;
  logic w_take;

  assign w_take = (r_state == DONE) & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mul_cnt <= '0;
      perf_div_cnt <= '0;
      r_is_div     <= 1'b0;
    end else if (!bus.flush) begin
      if (w_accept) r_is_div <= bus.in_funct3[2];
      if (w_take) begin
        if (r_is_div) perf_div_cnt <= perf_div_cnt + 32'd1;
        else          perf_mul_cnt <= perf_mul_cnt + 32'd1;
      end
    end
  end
`else
  // Counters are absent in this build.
`endif

endmodule

// File: tb/tb_ysyx_25040109_mdu.sv
// tb/tb_ysyx_25040109_mdu.sv - scoreboard bench for the multiply/divide unit
// Directed test-plan vectors, backpressure, flush and a short random sweep against a reference model.
module tb_ysyx_25040109_mdu;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ysyx_25040109_mdu_if #(.XLEN(32), .TAG_W(5)) bus ();

`ifdef YSYX_25040109_MDU_PERF_EN
  logic [31:0] perf_mul_cnt;
  logic [31:0] perf_div_cnt;
  int          exp_mul = 0;
  int          exp_div = 0;
`endif

  ysyx_25040109_mdu #(.XLEN(32), .MUL_STAGES(2), .TAG_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef YSYX_25040109_MDU_PERF_EN
    .perf_mul_cnt (perf_mul_cnt),
    .perf_div_cnt (perf_div_cnt),
`endif
    .bus          (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    logic        is_div;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_drop;
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0]        ua, ub, sa, sb, p;
    logic signed [31:0] q, r;
    logic               ovf;
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hffff_ffff);
    q   = 32'sd0;
    r   = 32'sd0;
    if (b != 32'd0 && !ovf) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    case (f)
      3'd0: begin p = ua * ub; ref_res = p[31:0];  end
      3'd1: begin p = sa * sb; ref_res = p[63:32]; end
      3'd2: begin p = sa * ub; ref_res = p[63:32]; end
      3'd3: begin p = ua * ub; ref_res = p[63:32]; end
      3'd4: ref_res = (b == 32'd0) ? 32'hffff_ffff : (ovf ? a : q);
      3'd5: ref_res = (b == 32'd0) ? 32'hffff_ffff : a / b;
      3'd6: ref_res = (b == 32'd0) ? a : (ovf ? 32'd0 : r);
      default: ref_res = (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hffff_ffff) return 1;
    return 33;
  endfunction

  task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [31:0] res, input int lat);
    exp_t e;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    e.res    = res;
    e.tag    = tag;
    e.lat    = lat;
    e.is_div = f[2];
    sb_q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int   n;
    exp_t e;
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    chk("latency", n, e.lat);
    chk("result", bus.out_result, e.res);
    chk("tag", 32'(bus.out_tag), 32'(e.tag));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_funct3 = 3'd0;
      bus.in_a      = 32'hdead_beef;
      bus.in_tag    = 5'h1f;
      @(negedge clk);
      chk("hold_result", bus.out_result, e.res);
      chk("hold_tag", 32'(bus.out_tag), 32'(e.tag));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("post_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef YSYX_25040109_MDU_PERF_EN
    if (e.is_div) exp_div++;
    else          exp_mul++;
`endif
  endtask

  initial begin
    logic        seen;
    logic [2:0]  f;
    logic [31:0] a, b;

    bus.in_valid  = 1'b0;
    bus.in_funct3 = 3'd0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_tag    = 5'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef YSYX_25040109_MDU_PERF_EN
    chk("rst_perf_mul", perf_mul_cnt, 32'd0);
    chk("rst_perf_div", perf_div_cnt, 32'd0);
`endif
    rst = 1'b0;

    send(3'd0, 32'd7, 32'hffff_fffd, 5'd3, 32'hffff_ffeb, 2);          collect(0);
    send(3'd3, 32'hffff_ffff, 32'hffff_ffff, 5'd4, 32'hffff_fffe, 2);  collect(0);
    send(3'd2, 32'hffff_ffff, 32'd2, 5'd5, 32'hffff_ffff, 2);          collect(0);
    send(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, 2);  collect(0);
    send(3'd4, 32'hffff_fff9, 32'd2, 5'd7, 32'hffff_fffd, 33);         collect(0);
    send(3'd6, 32'hffff_fff9, 32'd2, 5'd8, 32'hffff_ffff, 33);         collect(0);
    send(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 33);                      collect(0);
    send(3'd7, 32'd100, 32'd7, 5'd10, 32'd2, 33);                      collect(0);
    send(3'd4, 32'd1234, 32'd0, 5'd11, 32'hffff_ffff, 1);              collect(0);
    send(3'd7, 32'd5, 32'd0, 5'd12, 32'd5, 1);                         collect(0);
    send(3'd4, 32'h8000_0000, 32'hffff_ffff, 5'd13, 32'h8000_0000, 1); collect(0);
    send(3'd6, 32'h8000_0000, 32'hffff_ffff, 5'd14, 32'd0, 1);         collect(0);

    send(3'd5, 32'd100, 32'd7, 5'd21, 32'd14, 33);                     collect(10);
    send(3'd0, 32'd6, 32'd9, 5'd22, 32'd54, 2);                        collect(0);

    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = 3'd4;
    bus.in_a      = 32'd1000;
    bus.in_b      = 32'd3;
    bus.in_tag    = 5'd23;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_div_busy", 32'(bus.busy), 32'd0);
    chk("flush_div_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush_div_no_output", 32'(seen), 32'd0);

    bus.in_valid  = 1'b1;
    bus.in_funct3 = 3'd5;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    chk("flush_accept_busy", 32'(bus.busy), 32'd0);
    chk("flush_accept_in_ready", 32'(bus.in_ready), 32'd1);

    send(3'd0, 32'd3, 32'd5, 5'd24, 32'd15, 2);
    for (int k = 0; k < 10 && !bus.out_valid; k++) @(negedge clk);
    chk("flush_hs_out_valid_before", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    e_drop = sb_q.pop_front();
    chk("flush_hs_out_valid_after", 32'(bus.out_valid), 32'd0);
    chk("flush_hs_busy", 32'(bus.busy), 32'd0);
`ifdef YSYX_25040109_MDU_PERF_EN
    chk("flush_perf_mul", perf_mul_cnt, 32'(exp_mul));
    chk("flush_perf_div", perf_div_cnt, 32'(exp_div));
`endif

    for (int i = 0; i < 10; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 2 == 1) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i == 4) b = 32'd0;
      send(f, a, b, 5'(i), ref_res(f, a, b), ref_lat(f, a, b));
      collect(0);
    end

`ifdef YSYX_25040109_MDU_PERF_EN
    chk("end_perf_mul", perf_mul_cnt, 32'(exp_mul));
    chk("end_perf_div", perf_div_cnt, 32'(exp_div));
`endif

    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = 3'd7;
    bus.in_a      = 32'd77;
    bus.in_b      = 32'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_result", bus.out_result, 32'd0);
`ifdef YSYX_25040109_MDU_PERF_EN
    chk("midrst_perf_mul", perf_mul_cnt, 32'd0);
    chk("midrst_perf_div", perf_div_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
